programmable_sequence_counter: RTL and testbench

- Counter that steps through a run-time programmable sequence of WIDTH-bit values held in a DEPTH-entry table.
- Replaces fixed hard-coded sequence counters: sequence contents, sequence length and traversal direction are all set at run time.
- After reset it behaves as a plain binary counter (identity table). Firmware or a controlling FSM reprograms it via a simple write port.

---
 rtl/seq_counter_pkg.sv | 14 +
 rtl/seq_table.sv | 35 +++
 rtl/programmable_sequence_counter.sv | 91 +++++++++
 tb/tb_programmable_sequence_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_counter_pkg.sv
// Shared definitions for the programmable sequence counter: direction encoding
// and the clamp applied to firmware-written last-index values.
package seq_counter_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Out-of-range last indices saturate to the final table entry.
  function automatic int unsigned clamp_last(input int unsigned data,
                                             input int unsigned depth);
    return (data >= depth) ? depth - 1 : data;
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH sequence table: resets to the identity pattern, one guarded
// write port, one asynchronous read port.
module seq_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             waddr_ok;

  // Only matters when DEPTH is not a power of two.
  assign waddr_ok = 32'(waddr) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(i);
      end
    end else if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/programmable_sequence_counter.sv
// Steps through a run-time programmable table of values, forward or backward,
// with a programmable sequence length and a one-cycle wrap pulse.
module programmable_sequence_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [WIDTH-1:0] tbl_data,
  input  logic             last_we,
  input  logic [AW-1:0]    last_data,
  output logic [WIDTH-1:0] count,
  output logic [AW-1:0]    idx,
  output logic             wrap
);

  logic [AW-1:0]    last;
  logic [AW-1:0]    last_new;
  logic [AW-1:0]    idx_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] count_nxt;

  assign last_new = AW'(clamp_last(32'(last_data), 32'(DEPTH)));

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (tbl_data),
    .raddr (idx_nxt),
    .rdata (rd_data)
  );

  // No handshake: every cycle with en=1 is exactly one step; the step always
  // uses the registered last, so a same-cycle last_we only affects later steps.
  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    if (en) begin
      if (dir == DIR_FWD) begin
        if (idx >= last) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end else begin
        if (idx == '0) begin
          idx_nxt  = last;
          wrap_nxt = 1'b1;
        end else if (idx > last) begin
          idx_nxt = last;
        end else begin
          idx_nxt = idx - AW'(1);
        end
      end
    end
  end

  // Forward a same-cycle write so count always mirrors the table at idx.
  assign count_nxt = (tbl_we && (tbl_addr == idx_nxt)) ? tbl_data : rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      last  <= AW'(DEPTH - 1);
      idx   <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      if (last_we) begin
        last <= last_new;
      end
      idx   <= idx_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_programmable_sequence_counter.sv
// Table-driven bench for programmable_sequence_counter: a DEPTH=16 instance
// for the main sequences and a DEPTH=12 instance for last-index clamping.
module tb_programmable_sequence_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [3:0] tbl_data;
  logic       last_we;
  logic [3:0] last_data;
  logic [3:0] count16, idx16, count12, idx12;
  logic       wrap16, wrap12;

  programmable_sequence_counter #(.WIDTH(4), .DEPTH(16)) dut (
    .clk (clk), .reset (reset), .en (en), .dir (dir),
    .tbl_we (tbl_we), .tbl_addr (tbl_addr), .tbl_data (tbl_data),
    .last_we (last_we), .last_data (last_data),
    .count (count16), .idx (idx16), .wrap (wrap16)
  );

  programmable_sequence_counter #(.WIDTH(4), .DEPTH(12)) dut12 (
    .clk (clk), .reset (reset), .en (en), .dir (dir),
    .tbl_we (tbl_we), .tbl_addr (tbl_addr), .tbl_data (tbl_data),
    .last_we (last_we), .last_data (last_data),
    .count (count12), .idx (idx12), .wrap (wrap12)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       we;
    logic [3:0] addr;
    logic [3:0] data;
    logic       lwe;
    logic [3:0] ldata;
    logic [3:0] e_cnt;
    logic [3:0] e_idx;
    logic       e_wrap;
    logic       sel12;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         prog_seq[11] = '{0, 2, 5, 3, 6, 8, 4, 1, 9, 13, 12};

  function automatic void add(input logic rst, input logic e, input logic d,
                              input logic we, input int addr, input int data,
                              input logic lwe, input int ldata,
                              input int ec, input int ei, input logic ew,
                              input logic sel12);
    vec_t v;
    v.rst = rst; v.en = e; v.dir = d; v.we = we;
    v.addr = 4'(addr); v.data = 4'(data);
    v.lwe = lwe; v.ldata = 4'(ldata);
    v.e_cnt = 4'(ec); v.e_idx = 4'(ei); v.e_wrap = ew;
    v.sel12 = sel12;
    vecs.push_back(v);
  endfunction

  function automatic void step(input logic d, input int ec, input int ei, input logic ew);
    add(1'b0, 1'b1, d, 1'b0, 0, 0, 1'b0, 0, ec, ei, ew, 1'b0);
  endfunction

  function automatic void set_last(input int l, input int ec, input int ei);
    add(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, l, ec, ei, 1'b0, 1'b0);
  endfunction

  // Driver + scoreboard: push expectation with the stimulus, pop after the edge.
  task automatic apply(input vec_t v, input int n);
    logic [8:0] got, exp;
    @(negedge clk);
    reset = v.rst; en = v.en; dir = v.dir;
    tbl_we = v.we; tbl_addr = v.addr; tbl_data = v.data;
    last_we = v.lwe; last_data = v.ldata;
    exp_q.push_back({v.e_cnt, v.e_idx, v.e_wrap});
    @(posedge clk);
    #1;
    got = v.sel12 ? {count12, idx12, wrap12} : {count16, idx16, wrap16};
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL vec%0d%s: got count=%0d idx=%0d wrap=%0b, expected count=%0d idx=%0d wrap=%0b",
               n, v.sel12 ? " (depth12)" : "", got[8:5], got[4:1], got[0],
               exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; tbl_we = 1'b0;
    tbl_addr = '0; tbl_data = '0; last_we = 1'b0; last_data = '0;

    // Reset wins over en; then plain binary count with wrap on 15->0.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++) step(0, k % 16, k % 16, k == 16);

    // Program 0,2,5,3,6,8,4,1,9,13,12 at idx 0 with en low; last=10.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) add(0, 0, 0, 1, i, prog_seq[i], 0, 0, 0, 0, 0, 0);
    set_last(10, 0, 0);
    for (int j = 1; j <= 12; j++) step(0, prog_seq[j % 11], j % 11, j == 11);

    // Backward through 0, wrap to last, dir switches.
    step(1, 0, 0, 0);
    step(1, 12, 10, 1);
    step(1, 13, 9, 0);
    step(0, 12, 10, 0);
    step(0, 0, 0, 1);
    step(0, 2, 1, 0);
    step(0, 5, 2, 0);
    step(0, 3, 3, 0);

    // Forwarding on the step target; writes elsewhere appear later.
    add(0, 1, 0, 1, 4, 7, 0, 0, 7, 4, 0, 0);
    add(0, 0, 0, 1, 5, 11, 0, 0, 7, 4, 0, 0);
    add(0, 0, 0, 1, 4, 7, 0, 0, 7, 4, 0, 0);
    step(0, 11, 5, 0);
    step(0, 4, 6, 0);
    step(0, 1, 7, 0);
    step(0, 9, 8, 0);

    // Shrink last to 5 while stepping at idx 8: old last used, then wrap.
    add(0, 1, 0, 0, 0, 0, 1, 5, 13, 9, 0, 0);
    step(0, 0, 0, 1);

    // Shrink below idx then step backward: lands on last without wrap.
    set_last(10, 0, 0);
    step(0, 2, 1, 0);
    step(0, 5, 2, 0);
    step(0, 3, 3, 0);
    step(0, 7, 4, 0);
    step(0, 11, 5, 0);
    step(0, 4, 6, 0);
    step(0, 1, 7, 0);
    set_last(3, 1, 7);
    step(1, 3, 3, 0);

    // Reset mid-run at idx 6 restores identity table.
    set_last(10, 3, 3);
    step(0, 7, 4, 0);
    step(0, 11, 5, 0);
    step(0, 4, 6, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 2, 2, 0);
    step(0, 3, 3, 0);

    // last=0: every enabled step holds idx 0 and pulses wrap.
    set_last(0, 3, 3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // DEPTH=12 instance: last_data=15 clamps to 11, so wrap after idx 11.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 0, 1);
    for (int k = 1; k <= 12; k++) add(0, 1, 0, 0, 0, 0, 0, 0, k % 12, k % 12, k == 12, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    @(negedge clk);
    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
